// File: rtl/fft_corr_job_scheduler_pkg.sv
// Shared types for the FFT correlation job scheduler.
// States, job descriptor and status word layouts.
package fft_corr_pkg;

  localparam int JOB_W  = 30;
  localparam int STAT_W = 32;
  localparam int LEN_W  = 13;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_RUN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [3:0]       shift;
    logic [LEN_W-1:0] n2;
    logic [LEN_W-1:0] n1;
  } job_t;

  typedef struct packed {
    logic [6:0]       rsvd;
    logic [LEN_W-1:0] beats;
    logic             timeout;
    logic             len_err;
    logic             invalid;
    logic             overflow;
    logic [7:0]       job_id;
  } stat_t;

endpackage

// File: rtl/fft_corr_job_scheduler_if.sv
// Valid/ready stream bundle used for job and status ports.
// Width set per instance.
interface fft_corr_if #(
  parameter int W = 32
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/fft_corr_job_scheduler_fifo.sv
// Job descriptor FIFO, first-word-fall-through read.
// DEPTH must be a power of two.
module fft_corr_job_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 30
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] din,
  input  logic         rd_en,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          wr;
  logic          rd;

  assign wr    = wr_en && !full;
  assign rd    = rd_en && !empty;
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign dout  = mem[rp];

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (rd) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/fft_corr_job_scheduler.sv
// Sequences queued correlation jobs through the FFT core.
// Optional watchdog: define FFT_CORR_SCHED_TIMEOUT_EN.
module fft_corr_job_scheduler
  import fft_corr_pkg::*;
#(
  parameter int NFFT           = 256,
  parameter int JOB_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             aclk,
  input  logic             aresetn,
  fft_corr_if.slave        job,
  output logic [LEN_W-1:0] core_N1,
  output logic [LEN_W-1:0] core_N2,
  output logic [3:0]       core_IFFT_Shift,
  output logic             core_start,
  input  logic             core_idle,
  input  logic             core_overflow,
  input  logic             corr_tvalid_mon,
  input  logic             corr_tready_mon,
  fft_corr_if.master       stat,
  output logic             busy
);
  state_t            state;
  job_t              job_q;
  job_t              fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic [STAT_W-1:0] stat_q;
  logic              stat_v;
  stat_t             done_stat;
  stat_t             bad_stat;
  logic [7:0]        job_id;
  logic [LEN_W-1:0]  beats;
  logic [LEN_W-1:0]  beats_nx;
  logic              ovf;
  logic [LEN_W:0]    sum;
  logic [LEN_W:0]    len_exp;
  logic              job_ok;
  logic              run;
  logic              beat;
  logic              wd_hit;

  assign job.tready  = aresetn && !fifo_full;
  assign stat.tdata  = stat_q;
  assign stat.tvalid = stat_v;
  assign busy        = (state != S_IDLE) || !fifo_empty;
  assign pop = (state == S_IDLE) && !fifo_empty && core_idle;

  fft_corr_job_fifo #(
    .DEPTH (JOB_DEPTH),
    .W     (JOB_W)
  ) u_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .wr_en (job.tvalid && job.tready),
    .din   (job.tdata),
    .rd_en (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign sum     = {1'b0, job_q.n1} + {1'b0, job_q.n2};
  assign len_exp = sum - (LEN_W+1)'(1);
  assign job_ok  = (|job_q.n1) && (|job_q.n2) &&
                   (len_exp <= (LEN_W+1)'(NFFT));

  assign run  = (state == S_RUN);
  assign beat = corr_tvalid_mon && corr_tready_mon;
  assign beats_nx = (run && beat && !(&beats))
                  ? beats + LEN_W'(1) : beats;

`ifdef FFT_CORR_SCHED_TIMEOUT_EN
  logic [16:0] wd;

  // A beat in the limit cycle restarts the window instead of firing.
  assign wd_hit = (wd >= 17'(TIMEOUT_CYCLES - 1)) &&
                  ((state == S_WAIT_BUSY) || run) &&
                  !(run && beat);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wd <= '0;
    end else if (((state == S_WAIT_BUSY) || run) && !wd_hit) begin
      wd <= (run && beat) ? '0 : wd + 17'd1;
    end else begin
      wd <= '0;
    end
  end
`else
  logic unused_to;
  assign wd_hit    = 1'b0;
  assign unused_to = ^17'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    done_stat          = '0;
    done_stat.beats    = beats_nx;
    done_stat.timeout  = wd_hit;
    done_stat.len_err  = ({1'b0, beats_nx} != len_exp);
    done_stat.overflow = ovf || (run && core_overflow);
    done_stat.job_id   = job_id;
  end

  always_comb begin
    bad_stat         = '0;
    bad_stat.invalid = 1'b1;
    bad_stat.job_id  = job_id;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state           <= S_IDLE;
      job_q           <= '0;
      core_N1         <= '0;
      core_N2         <= '0;
      core_IFFT_Shift <= '0;
      core_start      <= 1'b0;
      stat_q          <= '0;
      stat_v          <= 1'b0;
      job_id          <= '0;
      beats           <= '0;
      ovf             <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            job_q <= fifo_dout;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (job_ok) begin
            core_N1         <= job_q.n1;
            core_N2         <= job_q.n2;
            core_IFFT_Shift <= job_q.shift;
            core_start      <= 1'b1;
            beats           <= '0;
            ovf             <= 1'b0;
            state           <= S_LAUNCH;
          end else begin
            stat_q <= bad_stat;
            stat_v <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_LAUNCH: begin
          core_start <= 1'b0;
          state      <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (wd_hit) begin
            stat_q <= done_stat;
            stat_v <= 1'b1;
            state  <= S_DONE;
          end else if (!core_idle) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          beats <= beats_nx;
          ovf   <= ovf || core_overflow;
          if (core_idle || wd_hit) begin
            stat_q <= done_stat;
            stat_v <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (stat.tready) begin
            stat_v <= 1'b0;
            job_id <= job_id + 8'd1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_corr_job_scheduler.sv
// Directed bench for fft_corr_job_scheduler.
// Bench drives the core handshake by hand.
module tb_fft_corr_job_scheduler;
  import fft_corr_pkg::*;

  logic        aclk    = 1'b0;
  logic        aresetn = 1'b1;
  logic [12:0] core_N1;
  logic [12:0] core_N2;
  logic [3:0]  core_IFFT_Shift;
  logic        core_start;
  logic        core_idle;
  logic        core_overflow;
  logic        corr_tvalid_mon;
  logic        corr_tready_mon;
  logic        busy;
  int          nvec   = 0;
  int          nerr   = 0;
  int          starts = 0;

  fft_corr_if #(.W(JOB_W))  job_if ();
  fft_corr_if #(.W(STAT_W)) stat_if ();

  fft_corr_job_scheduler #(
    .NFFT           (256),
    .JOB_DEPTH      (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .job             (job_if),
    .core_N1         (core_N1),
    .core_N2         (core_N2),
    .core_IFFT_Shift (core_IFFT_Shift),
    .core_start      (core_start),
    .core_idle       (core_idle),
    .core_overflow   (core_overflow),
    .corr_tvalid_mon (corr_tvalid_mon),
    .corr_tready_mon (corr_tready_mon),
    .stat            (stat_if),
    .busy            (busy)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) if (core_start) starts++;

  initial begin
    #1000000;
    $display("FAIL global_timeout: sim still running, need $finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int b, input logic to,
    input logic le, input logic inv, input logic ov,
    input logic [7:0] id);
    return {7'd0, 13'(b), to, le, inv, ov, id};
  endfunction

  function automatic logic [29:0] jd(input int n1, input int n2,
                                     input int sh);
    return {4'(sh), 13'(n2), 13'(n1)};
  endfunction

  task automatic push(input logic [29:0] d);
    int n = 0;
    job_if.tdata  = d;
    job_if.tvalid = 1'b1;
    while (!job_if.tready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    chk("push_ready", 32'(job_if.tready), 32'd1);
    @(negedge aclk);
    job_if.tvalid = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!core_start && n < 50) begin
      @(negedge aclk);
      n++;
    end
    chk("start_seen", 32'(core_start), 32'd1);
  endtask

  task automatic run_core(input int nb, input int ovf_at,
                          input bit gaps, output logic [12:0] n1);
    wait_start();
    n1 = core_N1;
    core_idle = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    for (int i = 0; i < nb; i++) begin
      if (gaps) begin
        corr_tvalid_mon = 1'b1;
        corr_tready_mon = 1'b0;
        @(negedge aclk);
      end
      corr_tvalid_mon = 1'b1;
      corr_tready_mon = 1'b1;
      core_overflow   = (i == ovf_at);
      if (i == nb - 1) core_idle = 1'b1;
      @(negedge aclk);
    end
    corr_tvalid_mon = 1'b0;
    corr_tready_mon = 1'b0;
    core_overflow   = 1'b0;
    core_idle       = 1'b1;
  endtask

  task automatic get_stat(input int hold, output logic [31:0] s);
    int n = 0;
    int s0;
    stat_if.tready = 1'b0;
    while (!stat_if.tvalid && n < 300) begin
      @(negedge aclk);
      n++;
    end
    chk("stat_valid", 32'(stat_if.tvalid), 32'd1);
    s  = stat_if.tdata;
    s0 = starts;
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      chk("stat_stable", stat_if.tdata, s);
    end
    if (hold > 0) chk("no_start_held", 32'(starts), 32'(s0));
    stat_if.tready = 1'b1;
    @(negedge aclk);
    stat_if.tready = 1'b0;
  endtask

  initial begin
    logic [31:0] s;
    logic [12:0] n1;
    core_idle       = 1'b1;
    core_overflow   = 1'b0;
    corr_tvalid_mon = 1'b0;
    corr_tready_mon = 1'b0;
    job_if.tdata    = '0;
    job_if.tvalid   = 1'b0;
    stat_if.tready  = 1'b0;
    #2 aresetn = 1'b0;
    @(negedge aclk);
    chk("rst_tready", 32'(job_if.tready), 32'd0);
    chk("rst_n1", 32'(core_N1), 32'd0);
    chk("rst_start", 32'(core_start), 32'd0);
    chk("rst_stat", stat_if.tdata, 32'd0);
    chk("rst_svalid", 32'(stat_if.tvalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst_tready", 32'(job_if.tready), 32'd1);

    push(jd(100, 50, 3));
    run_core(149, -1, 1'b0, n1);
    chk("t1_n1", 32'(n1), 32'd100);
    chk("t1_n2", 32'(core_N2), 32'd50);
    chk("t1_shift", 32'(core_IFFT_Shift), 32'd3);
    get_stat(0, s);
    chk("t1_stat", s, mk(149, 0, 0, 0, 0, 0));
    chk("t1_starts", 32'(starts), 32'd1);

    push(jd(200, 100, 0));
    get_stat(0, s);
    chk("t2_stat", s, mk(0, 0, 0, 1, 0, 1));
    chk("t2_starts", 32'(starts), 32'd1);
    chk("t2_n1_hold", 32'(core_N1), 32'd100);

    push(jd(200, 57, 1));
    run_core(256, -1, 1'b0, n1);
    get_stat(0, s);
    chk("len256_stat", s, mk(256, 0, 0, 0, 0, 2));
    push(jd(200, 58, 1));
    get_stat(0, s);
    chk("len257_stat", s, mk(0, 0, 0, 1, 0, 3));
    push(jd(0, 5, 0));
    get_stat(0, s);
    chk("n1zero_stat", s, mk(0, 0, 0, 1, 0, 4));
    push(jd(1, 1, 0));
    run_core(1, -1, 1'b0, n1);
    get_stat(0, s);
    chk("len1_stat", s, mk(1, 0, 0, 0, 0, 5));
    chk("bound_starts", 32'(starts), 32'd3);

    push(jd(8, 8, 2));
    run_core(10, 4, 1'b1, n1);
    get_stat(0, s);
    chk("t4_stat", s, mk(10, 0, 1, 0, 1, 6));

    core_idle = 1'b0;
    for (int i = 0; i < 4; i++) push(jd(3 + i, 2, i));
    chk("t3_full", 32'(job_if.tready), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    job_if.tdata  = jd(7, 2, 4);
    job_if.tvalid = 1'b1;
    repeat (3) @(negedge aclk);
    chk("t3_still_full", 32'(job_if.tready), 32'd0);
    chk("t3_no_start", 32'(starts), 32'd4);
    core_idle = 1'b1;
    push(jd(7, 2, 4));
    for (int i = 0; i < 5; i++) begin
      run_core(4 + i, -1, 1'b0, n1);
      chk("t3_order", 32'(n1), 32'(3 + i));
      get_stat((i == 0) ? 20 : 0, s);
      chk("t3_stat", s, mk(4 + i, 0, 0, 0, 0, 8'(7 + i)));
    end
    chk("t3_starts", 32'(starts), 32'd9);

    push(jd(8, 8, 0));
    wait_start();
    core_idle = 1'b0;
`ifdef FFT_CORR_SCHED_TIMEOUT_EN
    get_stat(0, s);
    chk("t6_timeout", s, mk(0, 1, 1, 0, 0, 12));
`else
    repeat (150) @(negedge aclk);
    chk("t6_no_stat", 32'(stat_if.tvalid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd1);
`endif
    push(jd(9, 9, 0));
    chk("t6_busy_q", 32'(busy), 32'd1);
    chk("t6_starts", 32'(starts), 32'd10);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_tready", 32'(job_if.tready), 32'd0);
    chk("arst_svalid", 32'(stat_if.tvalid), 32'd0);
    chk("arst_n1", 32'(core_N1), 32'd0);
    core_idle = 1'b1;
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (5) @(negedge aclk);
    chk("arst_discard", 32'(starts), 32'd10);
    chk("arst_idle", 32'(busy), 32'd0);
    push(jd(5, 5, 1));
    run_core(9, -1, 1'b0, n1);
    get_stat(0, s);
    chk("arst_jobid", s, mk(9, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
